// File: rtl/vec_adder_acc_if.sv
// vec_adder_acc_if: operand/result handshake bundle for vec_adder_acc.
// Carries the A and B operand channels and the C result channel, each with
// its own valid/ready pair. The producer/consumer side uses the master
// modport. The adder uses the slave modport.
interface vec_adder_acc_if #(
    parameter int ADDER_BITS = 8,
    parameter int LANES      = 4
);
    localparam int W = ADDER_BITS * LANES;

    // A operand channel (operation code travels with A)
    logic             a_valid;
    logic             a_ready;
    logic [W-1:0]     a_data;
    logic [1:0]       a_op;

    // B operand channel
    logic             b_valid;
    logic             b_ready;
    logic [W-1:0]     b_data;

    // C result channel
    logic             c_valid;
    logic             c_ready;
    logic [W-1:0]     c_data;
    logic [LANES-1:0] c_flag;

    modport master (
        output a_valid, a_data, a_op,
        output b_valid, b_data,
        output c_ready,
        input  a_ready, b_ready,
        input  c_valid, c_data, c_flag
    );

    modport slave (
        input  a_valid, a_data, a_op,
        input  b_valid, b_data,
        input  c_ready,
        output a_ready, b_ready,
        output c_valid, c_data, c_flag
    );
endinterface

// File: rtl/vec_adder_acc.sv
// vec_adder_acc: multi-lane handshaked adder/subtractor/accumulator.
// Joins one A vector (with its op code) and one B vector. Each pair produces
// one registered result vector on the C channel. Every lane is independent.
// Ops: 0 ADD, 1 SUB, 2 ACC (acc + a + b, stored), 3 LOAD (a + b, stored).
// Optional build macro VEC_ADDER_SAT_EN: lanes clamp instead of wrapping, and
// c_flag reports that a clamp occurred.
module vec_adder_acc #(
    parameter int ADDER_BITS = 8,
    parameter int LANES      = 4
) (
    input  logic             clock,
    input  logic             reset,
    vec_adder_acc_if.slave   bus
);
    localparam int W = ADDER_BITS * LANES;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_ACC  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    // Encoding chosen so bit 1 mirrors "A held" and bit 0 mirrors "B held".
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_HAVE_B = 2'b01,
        ST_HAVE_A = 2'b10,
        ST_FULL   = 2'b11
    } state_t;

    state_t           state_q, state_d;

    logic [W-1:0]     a_q, a_d;
    logic [1:0]       op_q, op_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             c_valid_q, c_valid_d;
    logic [W-1:0]     c_data_q, c_data_d;
    logic [LANES-1:0] c_flag_q, c_flag_d;

    logic             a_held, b_held;
    logic             fire;
    logic             a_ready, b_ready;
    logic             a_cap, b_cap;
    logic             a_keep, b_keep;

    // Per-lane results of the op held in op_q (combinational).
    logic [W-1:0]     lane_res;
    logic [LANES-1:0] lane_flag;

    // Join FSM: handshake decode and next held-slot state.
    always_comb begin
        a_held  = (state_q == ST_HAVE_A) || (state_q == ST_FULL);
        b_held  = (state_q == ST_HAVE_B) || (state_q == ST_FULL);
        // A pair leaves the slots only when the output register is free
        // or is being drained this same cycle.
        fire    = (state_q == ST_FULL) && (!c_valid_q || bus.c_ready);
        a_ready = !a_held || fire;
        b_ready = !b_held || fire;
        a_cap   = bus.a_valid && a_ready;
        b_cap   = bus.b_valid && b_ready;
        // A slot stays occupied after this edge if refilled or not consumed.
        a_keep  = a_cap || (a_held && !fire);
        b_keep  = b_cap || (b_held && !fire);
        state_d = state_q;
        case ({a_keep, b_keep})
            2'b00:   state_d = ST_EMPTY;
            2'b01:   state_d = ST_HAVE_B;
            2'b10:   state_d = ST_HAVE_A;
            default: state_d = ST_FULL;
        endcase
    end

    // Join FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ADDER_BITS-1:0] a_l, b_l, acc_l;
            logic [ADDER_BITS:0]   add_s, sub_s;
            logic [ADDER_BITS+1:0] acc_s;
            logic [ADDER_BITS-1:0] res;
            logic                  flg;

            assign a_l   = a_q[gi*ADDER_BITS +: ADDER_BITS];
            assign b_l   = b_q[gi*ADDER_BITS +: ADDER_BITS];
            assign acc_l = acc_q[gi*ADDER_BITS +: ADDER_BITS];

            // Lane arithmetic. ACC keeps two guard bits so that overflow of
            // either addition shows up as a nonzero upper field.
            always_comb begin
                add_s = {1'b0, a_l} + {1'b0, b_l};
                sub_s = {1'b0, a_l} - {1'b0, b_l};
                acc_s = {2'b00, acc_l} + {2'b00, a_l} + {2'b00, b_l};
                res   = add_s[ADDER_BITS-1:0];
                flg   = add_s[ADDER_BITS];
                case (op_q)
                    OP_SUB: begin
                        res = sub_s[ADDER_BITS-1:0];
                        flg = sub_s[ADDER_BITS];
                    end
                    OP_ACC: begin
                        res = acc_s[ADDER_BITS-1:0];
                        flg = |acc_s[ADDER_BITS+1:ADDER_BITS];
                    end
                    default: ;
                endcase
`ifdef VEC_ADDER_SAT_EN
                // Borrow clamps to zero, carry clamps to all-ones.
                if (flg) begin
                    res = (op_q == OP_SUB) ? '0 : '1;
                end
`endif
            end

            assign lane_res[gi*ADDER_BITS +: ADDER_BITS] = res;
            assign lane_flag[gi]                         = flg;
        end
    endgenerate

    // Datapath next state: operand capture, result load/drain, accumulator.
    always_comb begin
        a_d       = a_q;
        op_d      = op_q;
        b_d       = b_q;
        acc_d     = acc_q;
        c_valid_d = c_valid_q;
        c_data_d  = c_data_q;
        c_flag_d  = c_flag_q;
        if (a_cap) begin
            a_d  = bus.a_data;
            op_d = bus.a_op;
        end
        if (b_cap) begin
            b_d = bus.b_data;
        end
        if (fire) begin
            c_valid_d = 1'b1;
            c_data_d  = lane_res;
            c_flag_d  = lane_flag;
            // Only ACC and LOAD update acc. In saturating builds it stores the clamped value.
            if ((op_q == OP_ACC) || (op_q == OP_LOAD)) begin
                acc_d = lane_res;
            end
        end else if (c_valid_q && bus.c_ready) begin
            // Drained with nothing new: c_data keeps its last value.
            c_valid_d = 1'b0;
        end
    end

    // Datapath registers; reset drops held operands and any pending result.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q       <= '0;
            op_q      <= OP_ADD;
            b_q       <= '0;
            acc_q     <= '0;
            c_valid_q <= 1'b0;
            c_data_q  <= '0;
            c_flag_q  <= '0;
        end else begin
            a_q       <= a_d;
            op_q      <= op_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            c_valid_q <= c_valid_d;
            c_data_q  <= c_data_d;
            c_flag_q  <= c_flag_d;
        end
    end

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;
    assign bus.c_valid = c_valid_q;
    assign bus.c_data  = c_data_q;
    assign bus.c_flag  = c_flag_q;

endmodule

// File: tb/tb_vec_adder_acc.sv
// tb_vec_adder_acc: directed plus random bench for vec_adder_acc.
// The expected results come from a lane-arithmetic model that pairs accepted
// A and B beats in order. Build with VEC_ADDER_SAT_EN to check the
// saturating variant.
module tb_vec_adder_acc;
    localparam int AB   = 8;
    localparam int L    = 4;
    localparam int W    = AB * L;
    localparam int MAXV = (1 << AB) - 1;

`ifdef VEC_ADDER_SAT_EN
    localparam int OVF_ADD = 255;
    localparam int OVF_SUB = 0;
`else
    localparam int OVF_ADD = 44;
    localparam int OVF_SUB = 254;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic [L-1:0] f;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] d;
    } abeat_t;

    logic clock;
    logic reset;

    vec_adder_acc_if #(.ADDER_BITS(AB), .LANES(L)) bus ();

    vec_adder_acc #(.ADDER_BITS(AB), .LANES(L)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    int xfer_count    = 0;

    abeat_t       aq[$];
    logic [W-1:0] bq[$];
    exp_t         exp_q[$];
    logic [W-1:0] got_q[$];
    int           acc_m[L];

    logic         a_acc, b_acc, c_acc;
    logic         hold_v;
    logic [W-1:0] hold_d;
    logic [L-1:0] hold_f;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] vec(input int l0, input int l1, input int l2, input int l3);
        logic [W-1:0] r;
        r = {l3[AB-1:0], l2[AB-1:0], l1[AB-1:0], l0[AB-1:0]};
        return r;
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < L; i++) r[i*AB +: AB] = v[AB-1:0];
        return r;
    endfunction

    // Reference: lane-wise integer arithmetic, then wrap or clamp.
    task automatic model_pair(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int av, bv, s, r;
        logic over;
        for (int i = 0; i < L; i++) begin
            av = int'(a[i*AB +: AB]);
            bv = int'(b[i*AB +: AB]);
            case (op)
                2'd1:    s = av - bv;
                2'd2:    s = acc_m[i] + av + bv;
                default: s = av + bv;
            endcase
            over = (s > MAXV) || (s < 0);
`ifdef VEC_ADDER_SAT_EN
            r = (s > MAXV) ? MAXV : ((s < 0) ? 0 : s);
`else
            r = s & MAXV;
`endif
            if (op == 2'd2 || op == 2'd3) acc_m[i] = r;
            e.d[i*AB +: AB] = r[AB-1:0];
            e.f[i] = over;
        end
        exp_q.push_back(e);
    endtask

    function automatic void model_reset();
        aq.delete();
        bq.delete();
        exp_q.delete();
        for (int i = 0; i < L; i++) acc_m[i] = 0;
        hold_v = 1'b0;
    endfunction

    // One clock: observe handshakes at the falling edge, then advance to just past the rising edge.
    task automatic step();
        exp_t   e;
        abeat_t ab;
        @(negedge clock);
        a_acc = bus.a_valid && bus.a_ready;
        b_acc = bus.b_valid && bus.b_ready;
        c_acc = bus.c_valid && bus.c_ready;
        if (hold_v && !reset) begin
            check("c_hold_valid", bus.c_valid, 1'b1);
            check("c_hold_data", bus.c_data, hold_d);
            check("c_hold_flag", bus.c_flag, hold_f);
        end
        hold_v = bus.c_valid && !bus.c_ready;
        hold_d = bus.c_data;
        hold_f = bus.c_flag;
        if (c_acc && !reset) begin
            if (exp_q.size() == 0) begin
                check("c_unexpected_result", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                xfer_count++;
                $display("xfer %0d: c_data=%h c_flag=%b exp_data=%h exp_flag=%b",
                         xfer_count, bus.c_data, bus.c_flag, e.d, e.f);
                check("sb_data", bus.c_data, e.d);
                check("sb_flag", bus.c_flag, e.f);
                got_q.push_back(bus.c_data);
            end
        end
        if (a_acc && !reset) begin
            ab.op = bus.a_op;
            ab.d  = bus.a_data;
            aq.push_back(ab);
        end
        if (b_acc && !reset) bq.push_back(bus.b_data);
        while (aq.size() > 0 && bq.size() > 0) begin
            ab = aq.pop_front();
            model_pair(ab.op, ab.d, bq.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    // Offer A and/or B and wait (bounded) until each offered beat is taken.
    task automatic offer(input logic da, input logic [W-1:0] a, input logic [1:0] op,
                         input logic db, input logic [W-1:0] b);
        logic need_a, need_b;
        int n;
        need_a = da;
        need_b = db;
        n = 0;
        if (da) begin bus.a_valid = 1'b1; bus.a_data = a; bus.a_op = op; end
        if (db) begin bus.b_valid = 1'b1; bus.b_data = b; end
        while ((need_a || need_b) && n < 40) begin
            step();
            if (need_a && a_acc) begin need_a = 1'b0; bus.a_valid = 1'b0; end
            if (need_b && b_acc) begin need_b = 1'b0; bus.b_valid = 1'b0; end
            n++;
        end
        if (need_a || need_b) begin
            check("offer_timeout", 1'b1, 1'b0);
            bus.a_valid = 1'b0;
            bus.b_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        bus.c_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.c_valid) && n < 50) begin
            step();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_c_valid", bus.c_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.a_op    = 2'd0;
        bus.b_valid = 1'b0;
        bus.b_data  = '0;
        bus.c_ready = 1'b0;
        model_reset();
        a_acc = 1'b0; b_acc = 1'b0; c_acc = 1'b0;
        hold_d = '0; hold_f = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_a_ready", bus.a_ready, 1'b1);
        check("rst_b_ready", bus.b_ready, 1'b1);
        check("rst_c_valid", bus.c_valid, 1'b0);
        check("rst_c_data", bus.c_data, '0);
        check("rst_c_flag", bus.c_flag, '0);

        // Basic ADD, both operands in the same cycle: result two edges later
        bus.c_ready = 1'b1;
        bus.a_valid = 1'b1; bus.a_data = vec(1, 2, 3, 4); bus.a_op = 2'd0;
        bus.b_valid = 1'b1; bus.b_data = vec(10, 20, 30, 40);
        step();
        check("basic_a_taken", a_acc, 1'b1);
        check("basic_b_taken", b_acc, 1'b1);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        check("basic_latency_not_yet", bus.c_valid, 1'b0);
        step();
        check("basic_c_valid", bus.c_valid, 1'b1);
        check("basic_c_data", bus.c_data, vec(11, 22, 33, 44));
        check("basic_c_flag", bus.c_flag, 4'h0);
        drain();

        // Lane overflow and borrow
        offer(1'b1, rep(200), 2'd0, 1'b1, rep(100));
        step();
        check("ovf_add_data", bus.c_data, rep(OVF_ADD));
        check("ovf_add_flag", bus.c_flag, 4'hf);
        offer(1'b1, rep(5), 2'd1, 1'b1, rep(7));
        step();
        check("ovf_sub_data", bus.c_data, rep(OVF_SUB));
        check("ovf_sub_flag", bus.c_flag, 4'hf);
        drain();

        // B first, A three cycles later
        bus.b_valid = 1'b1; bus.b_data = vec(1, 1, 1, 1);
        step();
        check("ooo_b_taken", b_acc, 1'b1);
        bus.b_valid = 1'b0;
        check("ooo_b_ready_have_b", bus.b_ready, 1'b0);
        step();
        step();
        check("ooo_b_ready_still_low", bus.b_ready, 1'b0);
        bus.a_valid = 1'b1; bus.a_data = vec(5, 6, 7, 8); bus.a_op = 2'd0;
        step();
        check("ooo_a_taken", a_acc, 1'b1);
        bus.a_valid = 1'b0;
        check("ooo_b_ready_at_fire", bus.b_ready, 1'b1);
        step();
        check("ooo_c_valid", bus.c_valid, 1'b1);
        check("ooo_c_data", bus.c_data, vec(6, 7, 8, 9));
        drain();

        // Second A offered while waiting for B must stall
        bus.a_valid = 1'b1; bus.a_data = rep(9); bus.a_op = 2'd1;
        step();
        check("stall_a1_taken", a_acc, 1'b1);
        bus.a_data = rep(3); bus.a_op = 2'd0;
        check("stall_a_ready_low", bus.a_ready, 1'b0);
        step();
        check("stall_a2_not_taken", a_acc, 1'b0);
        offer(1'b1, rep(3), 2'd0, 1'b1, rep(4));
        offer(1'b0, '0, 2'd0, 1'b1, rep(2));
        drain();

        // Back-to-back accumulation
        got_q.delete();
        offer(1'b1, rep(1), 2'd3, 1'b1, rep(1));
        offer(1'b1, rep(3), 2'd2, 1'b1, rep(0));
        offer(1'b1, rep(0), 2'd2, 1'b1, rep(4));
        offer(1'b1, rep(1), 2'd0, 1'b1, rep(1));
        offer(1'b1, rep(1), 2'd2, 1'b1, rep(0));
        drain();
        check("acc_count", got_q.size(), 5);
        if (got_q.size() == 5) begin
            check("acc_load", got_q[0], rep(2));
            check("acc_acc1", got_q[1], rep(5));
            check("acc_acc2", got_q[2], rep(9));
            check("acc_add", got_q[3], rep(2));
            check("acc_acc3", got_q[4], rep(10));
        end

        // Backpressure: c_ready low for 5 cycles while streaming
        bus.c_ready = 1'b0;
        bus.a_valid = 1'b1; bus.a_data = W'($urandom); bus.a_op = 2'($urandom);
        bus.b_valid = 1'b1; bus.b_data = W'($urandom);
        for (int k = 0; k < 5; k++) begin
            step();
            if (a_acc) begin bus.a_data = W'($urandom); bus.a_op = 2'($urandom); end
            if (b_acc) bus.b_data = W'($urandom);
        end
        check("bp_a_ready", bus.a_ready, 1'b0);
        check("bp_b_ready", bus.b_ready, 1'b0);
        check("bp_c_valid", bus.c_valid, 1'b1);
        drain();

        // Reset while FULL with a pending result
        bus.c_ready = 1'b0;
        offer(1'b1, rep(7), 2'd0, 1'b1, rep(1));
        offer(1'b1, rep(9), 2'd2, 1'b1, rep(9));
        check("full_c_valid", bus.c_valid, 1'b1);
        check("full_a_ready", bus.a_ready, 1'b0);
        check("full_b_ready", bus.b_ready, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check("rst2_a_ready", bus.a_ready, 1'b1);
        check("rst2_b_ready", bus.b_ready, 1'b1);
        check("rst2_c_valid", bus.c_valid, 1'b0);
        check("rst2_c_data", bus.c_data, '0);
        check("rst2_c_flag", bus.c_flag, '0);
        bus.c_ready = 1'b1;
        offer(1'b1, rep(2), 2'd2, 1'b1, rep(3));
        step();
        check("rst2_acc_data", bus.c_data, rep(5));
        check("rst2_acc_flag", bus.c_flag, 4'h0);
        drain();

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            if (!bus.a_valid || a_acc) begin
                bus.a_valid = 1'($urandom);
                bus.a_data  = W'($urandom);
                bus.a_op    = 2'($urandom);
            end
            if (!bus.b_valid || b_acc) begin
                bus.b_valid = 1'($urandom);
                bus.b_data  = W'($urandom);
            end
            bus.c_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
